// File: rtl/window_pkg.sv
// Shared FSM encodings, read-enable codes and address helper for the window fetcher.
package window_pkg;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [1:0] REN_READ = 2'b10;
   localparam logic [1:0] REN_IDLE = 2'b00;

   localparam int unsigned CALC_W = 64;

   // Linear pixel address; callers truncate to their bus width.
   function automatic logic [CALC_W-1:0] win_addr(input logic [CALC_W-1:0] r,
                                                  input logic [CALC_W-1:0] c,
                                                  input logic [CALC_W-1:0] img_width,
                                                  input logic [CALC_W-1:0] base);
      return base + r * img_width + c;
   endfunction

endpackage

// File: rtl/window_coord_gen.sv
// Combinational window-pixel coordinate generator: raw signed (r,c), in-image flag, clamped (r,c).
module window_coord_gen
   import window_pkg::*;
#(
   parameter int unsigned WINDOW_SIZE = 3,
   parameter int unsigned BUS_WIDTH   = 32,
   parameter int unsigned IMG_WIDTH   = 512,
   parameter int unsigned IMG_HEIGHT  = 512,
   parameter int unsigned KW          = 4
) (
   input  logic [KW-1:0]          k,
   input  logic [BUS_WIDTH-1:0]   rcen,
   input  logic [BUS_WIDTH-1:0]   ccen,
   output logic signed [BUS_WIDTH:0] r,
   output logic signed [BUS_WIDTH:0] c,
   output logic                   in_image,
   output logic [BUS_WIDTH-1:0]   r_clamp,
   output logic [BUS_WIDTH-1:0]   c_clamp
);

   localparam int unsigned SW   = BUS_WIDTH + 1;
   localparam int unsigned HALF = WINDOW_SIZE / 2;

   logic [KW-1:0] row_off;
   logic [KW-1:0] col_off;
   logic          row_in;
   logic          col_in;

   always_comb begin
      row_off = KW'(k / KW'(WINDOW_SIZE));
      col_off = KW'(k % KW'(WINDOW_SIZE));
      r = $signed({1'b0, rcen}) - $signed(SW'(HALF)) + $signed(SW'(row_off));
      c = $signed({1'b0, ccen}) - $signed(SW'(HALF)) + $signed(SW'(col_off));
      row_in   = !r[SW-1] && (r[BUS_WIDTH-1:0] < BUS_WIDTH'(IMG_HEIGHT));
      col_in   = !c[SW-1] && (c[BUS_WIDTH-1:0] < BUS_WIDTH'(IMG_WIDTH));
      in_image = row_in && col_in;
      // Edge replication: negative goes to 0, past the edge goes to the last row/column.
      r_clamp = r[SW-1] ? '0 :
                (r[BUS_WIDTH-1:0] >= BUS_WIDTH'(IMG_HEIGHT)) ? BUS_WIDTH'(IMG_HEIGHT - 1) :
                r[BUS_WIDTH-1:0];
      c_clamp = c[SW-1] ? '0 :
                (c[BUS_WIDTH-1:0] >= BUS_WIDTH'(IMG_WIDTH)) ? BUS_WIDTH'(IMG_WIDTH - 1) :
                c[BUS_WIDTH-1:0];
   end

endmodule

// File: rtl/window_fetcher.sv
// Fetches a WSxWS pixel window around (row,col), one memory read per pixel, and holds it until Ack.
// Define WINDOW_BORDER_CLAMP_EN for edge replication; otherwise out-of-image pixels are zero-filled.
module window_fetcher
   import window_pkg::*;
#(
   parameter int unsigned WINDOW_SIZE = 3,
   parameter int unsigned DATA_WIDTH  = 24,
   parameter int unsigned BUS_WIDTH   = 32,
   parameter int unsigned IMG_WIDTH   = 512,
   parameter int unsigned IMG_HEIGHT  = 512,
   parameter int unsigned BASE_ADDR   = 0
) (
   input  logic                                         Wfet_Clk,
   input  logic                                         Wfet_Rset,
   input  logic                                         Wfet_Start,
   input  logic [BUS_WIDTH-1:0]                         Wfet_Rcen,
   input  logic [BUS_WIDTH-1:0]                         Wfet_Ccen,
   input  logic [DATA_WIDTH-1:0]                        Wfet_MemData,
   input  logic                                         Wfet_DRDY,
   input  logic                                         Wfet_Ack,
   output logic [BUS_WIDTH-1:0]                         Wfet_MemAddr,
   output logic [1:0]                                   Wfet_Ren,
   output logic [DATA_WIDTH*WINDOW_SIZE*WINDOW_SIZE-1:0] Wfet_Data,
   output logic                                         Wfet_RDY,
   output logic                                         Wfet_Busy
);

   localparam int unsigned NPIX = WINDOW_SIZE * WINDOW_SIZE;
   localparam int unsigned KW   = $clog2(NPIX);

   logic [1:0]            state, state_n;
   logic [KW-1:0]         k, k_n;
   logic [BUS_WIDTH-1:0]  rcen, rcen_n, ccen, ccen_n;
   logic [BUS_WIDTH-1:0]  addr_n;
   logic [1:0]            ren_n;
   logic                  rdy_n, busy_n;
   logic                  slot_we;
   logic [DATA_WIDTH-1:0] slot_wdata;
   logic                  zero_fill;
   logic [DATA_WIDTH-1:0] slots [NPIX];

   logic signed [BUS_WIDTH:0] r_raw, c_raw;
   logic                      in_image;
   logic [BUS_WIDTH-1:0]      r_clamp, c_clamp;
   logic                      unused_coord;

   window_coord_gen #(
      .WINDOW_SIZE (WINDOW_SIZE),
      .BUS_WIDTH   (BUS_WIDTH),
      .IMG_WIDTH   (IMG_WIDTH),
      .IMG_HEIGHT  (IMG_HEIGHT),
      .KW          (KW)
   ) u_coord (
      .k        (k),
      .rcen     (rcen),
      .ccen     (ccen),
      .r        (r_raw),
      .c        (c_raw),
      .in_image (in_image),
      .r_clamp  (r_clamp),
      .c_clamp  (c_clamp)
   );

   assign unused_coord = ^{r_raw, c_raw, in_image};

`ifdef WINDOW_BORDER_CLAMP_EN
   assign zero_fill = 1'b0;
`else
   assign zero_fill = !in_image;
`endif

   // Next-state and registered-output values.
   always_comb begin
      state_n    = state;
      k_n        = k;
      rcen_n     = rcen;
      ccen_n     = ccen;
      addr_n     = Wfet_MemAddr;
      ren_n      = REN_IDLE;
      slot_we    = 1'b0;
      slot_wdata = '0;
      case (state)
         S_IDLE: begin
            if (Wfet_Start) begin
               rcen_n  = Wfet_Rcen;
               ccen_n  = Wfet_Ccen;
               k_n     = '0;
               state_n = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (zero_fill) begin
               slot_we = 1'b1;
               if (k == KW'(NPIX - 1)) begin
                  state_n = S_DONE;
               end else begin
                  k_n     = k + KW'(1);
                  state_n = S_ISSUE;
               end
            end else begin
               addr_n  = BUS_WIDTH'(win_addr(CALC_W'(r_clamp), CALC_W'(c_clamp),
                                             CALC_W'(IMG_WIDTH), CALC_W'(BASE_ADDR)));
               ren_n   = REN_READ;
               state_n = S_WAIT;
            end
         end
         S_WAIT: begin
            if (Wfet_DRDY) begin
               slot_we    = 1'b1;
               slot_wdata = Wfet_MemData;
               if (k == KW'(NPIX - 1)) begin
                  state_n = S_DONE;
               end else begin
                  k_n     = k + KW'(1);
                  state_n = S_ISSUE;
               end
            end
         end
         S_DONE: begin
            if (Wfet_Ack) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
      rdy_n  = (state_n == S_DONE);
      busy_n = (state_n != S_IDLE);
   end

   always_ff @(posedge Wfet_Clk or posedge Wfet_Rset) begin
      if (Wfet_Rset) begin
         state <= S_IDLE;
         k     <= '0;
         rcen  <= '0;
         ccen  <= '0;
      end else begin
         state <= state_n;
         k     <= k_n;
         rcen  <= rcen_n;
         ccen  <= ccen_n;
      end
   end

   always_ff @(posedge Wfet_Clk or posedge Wfet_Rset) begin
      if (Wfet_Rset) begin
         Wfet_MemAddr <= '0;
         Wfet_Ren     <= REN_IDLE;
         Wfet_RDY     <= 1'b0;
         Wfet_Busy    <= 1'b0;
      end else begin
         Wfet_MemAddr <= addr_n;
         Wfet_Ren     <= ren_n;
         Wfet_RDY     <= rdy_n;
         Wfet_Busy    <= busy_n;
      end
   end

   // Window slot bank; contents persist after RDY drops until the next write or reset.
   always_ff @(posedge Wfet_Clk or posedge Wfet_Rset) begin
      if (Wfet_Rset) begin
         for (int i = 0; i < int'(NPIX); i++) slots[i] <= '0;
      end else if (slot_we) begin
         slots[k] <= slot_wdata;
      end
   end

   for (genvar g = 0; g < int'(NPIX); g++) begin : g_pack
      assign Wfet_Data[DATA_WIDTH*(NPIX-g)-1 -: DATA_WIDTH] = slots[g];
   end

endmodule
